// File: rtl/cim_bitserial_driver_pkg.sv
// Shared constants, FSM state type and lane indexing for the CIM bit-serial driver.
// Activations are packed lane-major: lane j occupies bits [j*ABITS +: ABITS].
package cim_bitserial_driver_pkg;

    localparam int CIM_ROWS  = 144;
    localparam int CIM_MAC_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int lane_idx(input int lane, input int abits, input int bitpos);
        return lane * abits + bitpos;
    endfunction

endpackage

// File: rtl/cim_shift_acc.sv
// Shift-accumulator for bit-serial MAC results, MSB plane first; one plane per enabled cycle.
// Holds its value whenever en is low, so the result stays stable while the consumer stalls.
module cim_shift_acc
    import cim_bitserial_driver_pkg::*;
#(
    parameter int MAC_W = CIM_MAC_W,
    parameter int ACC_W = CIM_MAC_W + 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             first,
    input  logic             act_signed,
    input  logic             sus,
    input  logic [MAC_W-1:0] mac,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] m;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    always_comb begin
        m     = sus ? {{(ACC_W-MAC_W){mac[MAC_W-1]}}, mac}
                    : {{(ACC_W-MAC_W){1'b0}}, mac};
        acc_d = acc_q;
        if (en) begin
            // A signed activation's MSB plane carries weight -2^(ABITS-1).
            if (first) begin
                acc_d = act_signed ? -m : m;
            end else begin
                acc_d = {acc_q[ACC_W-2:0], 1'b0} + m;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/cim_bitserial_driver.sv
// Bit-serial activation driver and result reader for the CIM MAC array; result ABITS edges after accept.
// A pending result blocks new vectors until out_ready; result handshake and next accept may share an edge.
module cim_bitserial_driver
    import cim_bitserial_driver_pkg::*;
#(
    parameter int ABITS = 8,
    parameter int ROWS  = CIM_ROWS,
    parameter int MAC_W = CIM_MAC_W,
    parameter int ACC_W = MAC_W + ABITS + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*ABITS-1:0] act_in,
    input  logic                  act_signed,
    input  logic                  w_signed,
    input  logic                  row_sel,
    output logic [ROWS-1:0]       rwlb_row0,
    output logic [ROWS-1:0]       rwlb_row1,
    output logic                  sus,
    input  logic [MAC_W-1:0]      mac_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      acc_out
);

    localparam int               CNT_W   = $clog2(ABITS);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(ABITS - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ROWS*ABITS-1:0]   act_q, act_d;
    logic                    act_signed_q, act_signed_d;
    logic                    sus_q, sus_d;
    logic                    row_sel_q, row_sel_d;
    logic                    out_valid_q, out_valid_d;
    logic [ROWS-1:0]         rwlb_row0_q, rwlb_row0_d;
    logic [ROWS-1:0]         rwlb_row1_q, rwlb_row1_d;
    logic [ROWS-1:0]         plane;
    logic                    accept;
    logic                    run_en;
    logic                    first;

    // Active-low wordline image of one activation bit-plane.
    function automatic logic [ROWS-1:0] plane_n(input logic [ROWS*ABITS-1:0] a, input int b);
        logic [ROWS-1:0] wl;
        for (int j = 0; j < ROWS; j++) begin
            wl[j] = ~a[lane_idx(j, ABITS, b)];
        end
        return wl;
    endfunction

    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign run_en   = (state_q == RUN);
    assign first    = run_en & (cnt_q == CNT_TOP);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        act_d        = act_q;
        act_signed_d = act_signed_q;
        sus_d        = sus_q;
        row_sel_d    = row_sel_q;
        out_valid_d  = out_valid_q;
        rwlb_row0_d  = '1;
        rwlb_row1_d  = '1;
        plane        = '1;

        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    // Wordlines are registered, so load the plane the next cycle will use.
                    plane = plane_n(act_q, int'(cnt_q) - 1);
                    if (row_sel_q) begin
                        rwlb_row1_d = plane;
                    end else begin
                        rwlb_row0_d = plane;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d      = RUN;
            cnt_d        = CNT_TOP;
            act_d        = act_in;
            act_signed_d = act_signed;
            sus_d        = w_signed;
            row_sel_d    = row_sel;
            plane        = plane_n(act_in, ABITS - 1);
            if (row_sel) begin
                rwlb_row1_d = plane;
            end else begin
                rwlb_row0_d = plane;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            act_q        <= '0;
            act_signed_q <= 1'b0;
            sus_q        <= 1'b0;
            row_sel_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            rwlb_row0_q  <= '1;
            rwlb_row1_q  <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act_q        <= act_d;
            act_signed_q <= act_signed_d;
            sus_q        <= sus_d;
            row_sel_q    <= row_sel_d;
            out_valid_q  <= out_valid_d;
            rwlb_row0_q  <= rwlb_row0_d;
            rwlb_row1_q  <= rwlb_row1_d;
        end
    end

    cim_shift_acc #(
        .MAC_W (MAC_W),
        .ACC_W (ACC_W)
    ) u_shift_acc (
        .clk        (clk),
        .rst        (rst),
        .en         (run_en),
        .first      (first),
        .act_signed (act_signed_q),
        .sus        (sus_q),
        .mac        (mac_out),
        .acc        (acc_out)
    );

    assign rwlb_row0 = rwlb_row0_q;
    assign rwlb_row1 = rwlb_row1_q;
    assign sus       = sus_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cim_bitserial_driver.sv
// Bench for cim_bitserial_driver: table vectors with a gated forced MAC value, random vectors
// against a dot-product reference with a behavioural MAC array, plus backpressure and reset sequences.
module tb_cim_bitserial_driver;

    localparam int ROWS  = 144;
    localparam int ACT_W = ROWS * 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ACT_W-1:0]  act_in;
    logic              act_signed;
    logic              w_signed;
    logic              row_sel;
    logic [ROWS-1:0]   rwlb_row0;
    logic [ROWS-1:0]   rwlb_row1;
    logic              sus;
    logic [11:0]       mac_out;
    logic              out_valid;
    logic              out_ready;
    logic [20:0]       acc_out;

    logic [3:0]        w0 [ROWS];
    logic [3:0]        w1 [ROWS];
    logic              force_en;
    logic [11:0]       force_val;
    int                mac_sum;
    int                cyc = 0;
    int                total = 0;
    int                bad = 0;

    cim_bitserial_driver #(.ABITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .act_in     (act_in),
        .act_signed (act_signed),
        .w_signed   (w_signed),
        .row_sel    (row_sel),
        .rwlb_row0  (rwlb_row0),
        .rwlb_row1  (rwlb_row1),
        .sus        (sus),
        .mac_out    (mac_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc_out    (acc_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MAC array: sums the weights of every lane whose wordline is pulled low.
    always_comb begin
        mac_sum = 0;
        for (int j = 0; j < ROWS; j++) begin
            if (!rwlb_row0[j]) mac_sum = mac_sum + (sus ? int'($signed(w0[j])) : int'(w0[j]));
            if (!rwlb_row1[j]) mac_sum = mac_sum + (sus ? int'($signed(w1[j])) : int'(w1[j]));
        end
        if (force_en) mac_out = ((~&rwlb_row0) | (~&rwlb_row1)) ? force_val : 12'd0;
        else          mac_out = mac_sum[11:0];
    end

    task automatic chk(input string nm, input logic [ROWS-1:0] got, input logic [ROWS-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic logic [ROWS-1:0] plane_n(input logic [ACT_W-1:0] a, input int b);
        logic [ROWS-1:0] p;
        for (int j = 0; j < ROWS; j++) p[j] = ~a[j*8 + b];
        return p;
    endfunction

    function automatic logic [ACT_W-1:0] fill(input logic [7:0] v);
        return {ROWS{v}};
    endfunction

    // Reference: full-precision dot product of activations with the selected weight row.
    function automatic logic [20:0] dot(input logic [ACT_W-1:0] a, input bit as, input bit ws, input bit rs);
        int s;
        int av;
        int wv;
        logic [3:0] w;
        s = 0;
        for (int j = 0; j < ROWS; j++) begin
            av = as ? int'($signed(a[j*8 +: 8])) : int'(a[j*8 +: 8]);
            w  = rs ? w1[j] : w0[j];
            wv = ws ? int'($signed(w)) : int'(w);
            s  = s + av * wv;
        end
        return 21'(s);
    endfunction

    task automatic start_op(input logic [ACT_W-1:0] a, input bit as, input bit ws, input bit rs,
                            input string nm);
        int n;
        act_in     = a;
        act_signed = as;
        w_signed   = ws;
        row_sel    = rs;
        in_valid   = 1'b1;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, "_accept"}, ROWS'(n < 50), ROWS'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        // Scramble the ignored inputs while the vector is being applied.
        act_in     = ~a;
        act_signed = ~as;
        w_signed   = ~ws;
        row_sel    = ~rs;
    endtask

    task automatic wait_valid(input logic [ACT_W-1:0] a, input bit ws, input bit rs, input bit chkwl,
                              input string nm, output int lat);
        logic [ROWS-1:0] pl;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (chkwl && lat < 8) begin
                pl = plane_n(a, 7 - lat);
                chk({nm, "_wl0"}, rwlb_row0, rs ? {ROWS{1'b1}} : pl);
                chk({nm, "_wl1"}, rwlb_row1, rs ? pl : {ROWS{1'b1}});
                chk({nm, "_sus"}, ROWS'(sus), ROWS'(ws));
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, ROWS'(lat), ROWS'(8));
    endtask

    task automatic do_op(input logic [ACT_W-1:0] a, input bit as, input bit ws, input bit rs,
                         input logic [20:0] exp, input string nm);
        int lat;
        out_ready = 1'b1;
        start_op(a, as, ws, rs, nm);
        wait_valid(a, ws, rs, 1'b1, nm, lat);
        chk({nm, "_acc"}, ROWS'(acc_out), ROWS'(exp));
        chk({nm, "_wlidle"}, ROWS'(&{rwlb_row0, rwlb_row1}), ROWS'(1));
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_drop"}, ROWS'(out_valid), ROWS'(0));
    endtask

    typedef struct {
        logic [7:0]  a;
        bit          as;
        bit          ws;
        bit          rs;
        logic [11:0] m;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t2;
        int t3;
        int seen;
        logic [ACT_W-1:0] a;
        bit as, ws, rs;

        tbl[0] = '{8'd255,  1'b0, 1'b0, 1'b0, 12'd100,  21'd25500};
        tbl[1] = '{8'd255,  1'b0, 1'b0, 1'b1, 12'd100,  21'd25500};
        tbl[2] = '{8'hFF,   1'b1, 1'b0, 1'b0, 12'd1,    21'(-1)};
        tbl[3] = '{8'h80,   1'b1, 1'b0, 1'b0, 12'd1,    21'(-128)};
        tbl[4] = '{8'd255,  1'b0, 1'b1, 1'b0, 12'hFFF,  21'(-255)};
        tbl[5] = '{8'd1,    1'b0, 1'b0, 1'b1, 12'd5,    21'd5};
        tbl[6] = '{8'h7F,   1'b1, 1'b0, 1'b0, 12'd3,    21'd381};
        tbl[7] = '{8'h80,   1'b1, 1'b1, 1'b1, 12'hFFF,  21'd128};
        tbl[8] = '{8'h80,   1'b0, 1'b1, 1'b0, 12'hFFF,  21'(-128)};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; act_in = '0;
        act_signed = 1'b0; w_signed = 1'b0; row_sel = 1'b0;
        force_en = 1'b1; force_val = 12'd0;
        for (int j = 0; j < ROWS; j++) begin w0[j] = 4'd0; w1[j] = 4'd0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", ROWS'(out_valid), ROWS'(0));
        chk("rst_acc", ROWS'(acc_out), ROWS'(0));
        chk("rst_sus", ROWS'(sus), ROWS'(0));
        chk("rst_wl0", rwlb_row0, {ROWS{1'b1}});
        chk("rst_wl1", rwlb_row1, {ROWS{1'b1}});
        chk("rst_ready", ROWS'(in_ready), ROWS'(1));
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            force_en  = 1'b1;
            force_val = tbl[i].m;
            do_op(fill(tbl[i].a), tbl[i].as, tbl[i].ws, tbl[i].rs, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Lane-ordered activations on row 1 against random weights.
        force_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < ROWS; j++) begin
                w0[j] = 4'($urandom); w1[j] = 4'($urandom);
                a[j*8 +: 8] = 8'(j % 256);
            end
            do_op(a, 1'b0, k[0], 1'b1, dot(a, 1'b0, k[0], 1'b1), $sformatf("order%0d", k));
        end

        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < ROWS; j++) begin
                w0[j] = 4'($urandom); w1[j] = 4'($urandom);
                a[j*8 +: 8] = 8'($urandom);
            end
            as = 1'($urandom_range(0, 1));
            ws = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            do_op(a, as, ws, rs, dot(a, as, ws, rs), $sformatf("rnd%0d", r));
        end

        // Backpressure, same-edge handshake+accept, and back-to-back throughput.
        force_en = 1'b1; force_val = 12'd100; out_ready = 1'b0;
        start_op(fill(8'd255), 1'b0, 1'b0, 1'b0, "bp1");
        wait_valid(fill(8'd255), 1'b0, 1'b0, 1'b1, "bp1", lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_valid", ROWS'(out_valid), ROWS'(1));
            chk("bp_hold_acc", ROWS'(acc_out), ROWS'(25500));
            chk("bp_hold_ready", ROWS'(in_ready), ROWS'(0));
            chk("bp_hold_wl", ROWS'(&{rwlb_row0, rwlb_row1}), ROWS'(1));
        end
        out_ready = 1'b1;
        start_op(fill(8'd1), 1'b0, 1'b0, 1'b0, "bp2");
        chk("bp2_handshake", ROWS'(out_valid), ROWS'(0));
        wait_valid(fill(8'd1), 1'b0, 1'b0, 1'b1, "bp2", lat);
        t2 = cyc;
        chk("bp2_acc", ROWS'(acc_out), ROWS'(100));
        start_op(fill(8'd2), 1'b0, 1'b0, 1'b0, "bp3");
        wait_valid(fill(8'd2), 1'b0, 1'b0, 1'b0, "bp3", lat);
        t3 = cyc;
        chk("bp_throughput", ROWS'(t3 - t2), ROWS'(9));
        chk("bp3_acc", ROWS'(acc_out), ROWS'(200));
        @(posedge clk);
        @(negedge clk);
        chk("bp3_drop", ROWS'(out_valid), ROWS'(0));

        // Reset during the 4th RUN cycle discards the operation.
        start_op(fill(8'd255), 1'b0, 1'b1, 1'b0, "mrst");
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mrst_sus_before", ROWS'(sus), ROWS'(1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_valid", ROWS'(out_valid), ROWS'(0));
        chk("mrst_sus", ROWS'(sus), ROWS'(0));
        chk("mrst_acc", ROWS'(acc_out), ROWS'(0));
        chk("mrst_wl", ROWS'(&{rwlb_row0, rwlb_row1}), ROWS'(1));
        chk("mrst_ready", ROWS'(in_ready), ROWS'(1));
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("mrst_no_result", ROWS'(seen), ROWS'(0));
        do_op(fill(8'd255), 1'b0, 1'b0, 1'b0, 21'd25500, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cim_bitserial_driver.md
Name: cim_bitserial_driver

Overview:
- Drives the CIM local MAC array with activations bit-serially and consumes its result; it is the input-side driver and result reader for that array.
- Accepts a vector of 144 multi-bit activations and applies one activation bit-plane per cycle, MSB first, on the active-low read wordlines of one selected weight row.
- Shift-accumulates the 12-bit combinational MAC result each cycle and returns the full-precision dot product over a valid/ready handshake.

Parameters:
- ABITS, 8, activation bit width (range 2..16).
- ROWS, 144, number of MAC lanes.
- MAC_W, 12, width of the MAC array result.
- ACC_W, MAC_W+ABITS+1 (21), accumulator/result width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  activation vector valid.
- in_ready  out  1  block can accept a vector.
- act_in  in  ROWS*ABITS  activations; lane j = act_in[j*ABITS +: ABITS].
- act_signed  in  1  activations are two's complement.
- w_signed  in  1  weights are signed; sampled on accept.
- row_sel  in  1  0 = weight row 0, 1 = weight row 1; sampled on accept.
- rwlb_row0  out  ROWS  active-low wordlines, row 0.
- rwlb_row1  out  ROWS  active-low wordlines, row 1.
- sus  out  1  MAC signed-add mode = captured w_signed.
- mac_out  in  MAC_W  combinational MAC array result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- acc_out  out  ACC_W  signed dot-product result.

Behaviour:
- Reset values, effective on the edge rst is sampled high, including mid-operation:
  - rwlb_row0 and rwlb_row1 all ones (no row selected).
  - sus=0, out_valid=0, acc_out=0, state IDLE.
  - Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept: on an edge with in_valid & in_ready.
  - Latch act_in, act_signed, w_signed (to sus), and row_sel.
  - Set bit counter cnt = ABITS-1 and go to RUN.
- Wordline drive (all wordline outputs registered):
  - During RUN, the selected row carries the inverse of activation bit cnt for every lane: rwlb_rowX[j] = ~act[j][cnt].
  - The unselected row is all ones.
  - In IDLE and DONE both rows are all ones.
- Each RUN edge:
  - m = sus ? sign-extend(mac_out) : zero-extend(mac_out), extended to ACC_W.
  - MSB cycle (cnt==ABITS-1): acc = act_signed ? -m : m.
  - Other cycles: acc = (acc<<1) + m.
  - cnt decrements. On the cnt==0 edge go to DONE and set out_valid=1.
- Latency: out_valid rises exactly ABITS edges after the accept edge. acc_out is held stable while out_valid=1.
- DONE:
  - out_valid & out_ready: handshake completes.
  - If in_valid is also high on that edge, the next vector is accepted on the same edge and the block goes directly to RUN.
  - Otherwise the block goes to IDLE and out_valid falls.
  - Sustained throughput: one result per ABITS+1 cycles.
- Inputs in_valid, act_in, row_sel, act_signed and w_signed are ignored while in RUN. sus changes only on accept or reset.
- Arithmetic range:
  - ACC_W holds the full range: unsigned max 144*15*255 < 2^20.
  - Signed extremes fit in 21-bit two's complement.
  - No saturation is applied.

Decomposition:
- Shared package:
  - ROWS=144 and MAC_W=12.
  - FSM state enum {IDLE, RUN, DONE}.
  - Function for the lane slice index.
- One sub-module: cim_shift_acc. It contains the extend/negate/shift-add datapath and takes m, first-cycle, act_signed and enable as inputs.
- The top level holds the FSM, the wordline registers and the handshake.

Test Plan (bench models the MAC as a behavioural dot product or forces mac_out directly; ABITS=8):
1. act lanes all 8'd255, unsigned, row_sel=0, mac_out forced 12'd100 -> acc_out=25500; each RUN cycle rwlb_row0=0 and rwlb_row1=all ones; out_valid rises 8 edges after accept.
2. act_signed=1, act lanes all 8'hFF, mac_out forced 12'd1 -> acc_out=-1; act all 8'h80 -> acc_out=-128.
3. w_signed=1, unsigned act all 8'd255, mac_out forced 12'hFFF -> sus=1 throughout, acc_out=-255.
4. Row/bit order check: row_sel=1, act[j]=j mod 256 -> rwlb_row0 all ones; on cycle k, rwlb_row1[j] = ~act[j][7-k]. Compare acc_out with the behavioural dot product computed from random weights.
5. Backpressure: hold out_ready=0 for 5 cycles -> out_valid and acc_out stable, in_ready=0, wordlines all ones. Then raise out_ready with in_valid=1 -> same-edge accept, and the next result arrives 9 cycles after the first.
6. Assert rst on the 4th RUN cycle -> next cycle state IDLE, out_valid=0, wordlines all ones, sus=0. A following operation from scenario 1 still returns 25500.
